// File: rtl/cpu_pkg.sv
// Shared CPU package: RV32I opcode constants, well-known instruction words
// and the default reset PC used by the fetch stage.
package cpu_pkg;

   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_NOP   = 32'h0000_0013;
   localparam logic [31:0] INST_ECALL = 32'h0000_0073;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and an asynchronous-read memory.
//   I_MEM_ADDR : word address driven by fetch
//   I_MEM_DI   : instruction word returned combinationally by memory
interface fetch_unit_if #(
   parameter int unsigned IMEM_AW = 12
);

   logic [IMEM_AW-1:0] I_MEM_ADDR;
   logic [31:0]        I_MEM_DI;

   modport master (output I_MEM_ADDR, input I_MEM_DI);
   modport slave  (input I_MEM_ADDR, output I_MEM_DI);

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC selection, purely combinational.
//   pc_i, imm_i, alu_result_i         : operands
//   jump_i, jal_or_jalr_i, branch_i,
//   bcond_i                           : control / compare inputs
//   pc_next_o                         : word-aligned committed target
//   misalign_o                        : raw target had bit 1 set
module pc_next_mux (
   input  logic [31:0] pc_i,
   input  logic [31:0] imm_i,
   input  logic [31:0] alu_result_i,
   input  logic        jump_i,
   input  logic        jal_or_jalr_i,
   input  logic        branch_i,
   input  logic        bcond_i,
   output logic [31:0] pc_next_o,
   output logic        misalign_o
);

   logic [31:0] target;

   always_comb begin
      target = pc_i + 32'd4;
      // Jump outranks branch when both are asserted.
      if (jump_i && jal_or_jalr_i) begin
         target = alu_result_i & 32'hFFFF_FFFE;
      end else if (jump_i) begin
         target = pc_i + imm_i;
      end else if (branch_i && bcond_i) begin
         target = pc_i + imm_i;
      end
      misalign_o = target[1];
      pc_next_o  = target & 32'hFFFF_FFFC;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage of the multi-cycle CPU.
//   CLK, RSTn          : clock, synchronous active-low reset
//   PCWrite            : commit next PC, instruction retires
//   Jump, JALorJALR,
//   Branch, BCOND      : target selection
//   ALU_RESULT, IMM    : target operands
//   imem               : instruction-memory bus (address out, word in)
//   INST, PC, PC_PLUS4 : current instruction, its PC and link value
//   NUM_INST           : retired-instruction count
//   HALT, MISALIGN     : sticky status flags
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned IMEM_AW  = 12
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                PCWrite,
   input  logic                Jump,
   input  logic                JALorJALR,
   input  logic                Branch,
   input  logic                BCOND,
   input  logic [31:0]         ALU_RESULT,
   input  logic [31:0]         IMM,
   fetch_unit_if.master        imem,
   output logic [31:0]         INST,
   output logic [31:0]         PC,
   output logic [31:0]         PC_PLUS4,
   output logic [31:0]         NUM_INST,
   output logic                HALT,
   output logic                MISALIGN
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        f_q, f_d;
   logic [31:0] num_inst_q, num_inst_d;
   logic        halt_q, halt_d;
   logic        misalign_q, misalign_d;

   logic [31:0] pc_next;
   logic        target_misalign;
   logic        accept;

   pc_next_mux u_pc_next_mux (
      .pc_i          (pc_q),
      .imm_i         (IMM),
      .alu_result_i  (ALU_RESULT),
      .jump_i        (Jump),
      .jal_or_jalr_i (JALorJALR),
      .branch_i      (Branch),
      .bcond_i       (BCOND),
      .pc_next_o     (pc_next),
      .misalign_o    (target_misalign)
   );

   always_comb begin
      accept     = PCWrite && !halt_q;
      pc_d       = accept ? pc_next : pc_q;
      f_d        = accept;
      // Halted state freezes IR even if a fetch cycle was still pending.
      ir_d       = (f_q && !halt_q) ? imem.I_MEM_DI : ir_q;
      num_inst_d = num_inst_q + {31'd0, accept};
      misalign_d = misalign_q | (accept & target_misalign);
      // ECALL is recognised once it sits in IR (decode cycle, F=0).
      halt_d     = halt_q | (!f_q && (ir_q == INST_ECALL));
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         pc_q       <= RESET_PC;
         ir_q       <= INST_NOP;
         f_q        <= 1'b1;
         num_inst_q <= 32'd0;
         halt_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         f_q        <= f_d;
         num_inst_q <= num_inst_d;
         halt_q     <= halt_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem.I_MEM_ADDR = pc_q[IMEM_AW+1:2];
   assign INST            = f_q ? imem.I_MEM_DI : ir_q;
   assign PC              = pc_q;
   assign PC_PLUS4        = pc_q + 32'd4;
   assign NUM_INST        = num_inst_q;
   assign HALT            = halt_q;
   assign MISALIGN        = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        PCWrite, Jump, JALorJALR, Branch, BCOND;
   logic [31:0] ALU_RESULT, IMM;
   logic [31:0] INST, PC, PC_PLUS4, NUM_INST;
   logic        HALT, MISALIGN;

   logic [31:0] mem [4096];
   int          checks   = 0;
   int          failures = 0;

   fetch_unit_if #(.IMEM_AW(12)) imem_bus ();

   assign imem_bus.I_MEM_DI = mem[imem_bus.I_MEM_ADDR];

   fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(12)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .PCWrite    (PCWrite),
      .Jump       (Jump),
      .JALorJALR  (JALorJALR),
      .Branch     (Branch),
      .BCOND      (BCOND),
      .ALU_RESULT (ALU_RESULT),
      .IMM        (IMM),
      .imem       (imem_bus),
      .INST       (INST),
      .PC         (PC),
      .PC_PLUS4   (PC_PLUS4),
      .NUM_INST   (NUM_INST),
      .HALT       (HALT),
      .MISALIGN   (MISALIGN)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ctrl(input logic pw, input logic j, input logic jj, input logic br,
                       input logic bc, input logic [31:0] alu, input logic [31:0] imm);
      PCWrite = pw; Jump = j; JALorJALR = jj; Branch = br; BCOND = bc;
      ALU_RESULT = alu; IMM = imm;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0013;
      mem[0] = 32'h0050_0093;
      mem[2] = 32'h00A0_0113;
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      RSTn = 1'b0;
      step();
      step();
      RSTn = 1'b1;

      // Reset state and first fetch.
      check("rst_pc", PC, 32'h0);
      check("rst_inst", INST, 32'h0050_0093);
      check("rst_num", NUM_INST, 32'd0);
      check("rst_halt", {31'd0, HALT}, 32'd0);
      check("rst_mis", {31'd0, MISALIGN}, 32'd0);
      check("rst_addr", {20'd0, imem_bus.I_MEM_ADDR}, 32'd0);
      check("rst_plus4", PC_PLUS4, 32'h4);

      // Two back-to-back sequential commits.
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      check("seq_pc4", PC, 32'h4);
      step();
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("seq_pc8", PC, 32'h8);
      check("seq_num2", NUM_INST, 32'd2);
      check("seq_inst_fetch", INST, 32'h00A0_0113);

      // After F clears INST comes from IR, not from memory.
      step();
      mem[2] = 32'h0000_0000;
      #1;
      check("ir_hold", INST, 32'h00A0_0113);
      check("idle_pc", PC, 32'h8);
      mem[2] = 32'h0000_0013;

      // Advance to 0x10, then taken branch back by 8.
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      check("pc_10", PC, 32'h10);
      ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFF8);
      step();
      check("br_taken", PC, 32'h8);
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFF8);
      step();
      check("br_not_taken", PC, 32'h14);
      check("num_8", NUM_INST, 32'd8);

      // Advance to 0x20, then JALR targets.
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      step();
      check("pc_20", PC, 32'h20);
      ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0105, 32'd0);
      step();
      check("jalr_pc", PC, 32'h104);
      check("jalr_mis0", {31'd0, MISALIGN}, 32'd0);
      ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0106, 32'd0);
      step();
      check("jalr_mis_pc", PC, 32'h104);
      check("jalr_mis1", {31'd0, MISALIGN}, 32'd1);

      // Jump beats a simultaneous taken branch.
      ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd0);
      step();
      check("pc_100", PC, 32'h100);
      ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'h0000_0040);
      step();
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("jal_prio", PC, 32'h140);
      check("jal_plus4", PC_PLUS4, 32'h144);
      check("jal_addr", {20'd0, imem_bus.I_MEM_ADDR}, 32'h50);
      check("num_15", NUM_INST, 32'd15);
      check("mis_sticky", {31'd0, MISALIGN}, 32'd1);

      // Reset with PCWrite held high: reset wins.
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      RSTn = 1'b0;
      step();
      RSTn = 1'b1;
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("rst2_pc", PC, 32'h0);
      check("rst2_num", NUM_INST, 32'd0);
      check("rst2_mis", {31'd0, MISALIGN}, 32'd0);
      check("rst2_inst", INST, 32'h0050_0093);
      check("rst2_ir", dut.ir_q, 32'h0000_0013);

      // ECALL at 0x8 halts two cycles after PC reaches it.
      mem[2] = 32'h0000_0073;
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("halt_pc8", PC, 32'h8);
      check("halt_pre0", {31'd0, HALT}, 32'd0);
      step();
      check("halt_pre1", {31'd0, HALT}, 32'd0);
      step();
      check("halt_set", {31'd0, HALT}, 32'd1);
      ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      step();
      check("halt_pc_frozen", PC, 32'h8);
      check("halt_num_frozen", NUM_INST, 32'd2);
      check("halt_inst", INST, 32'h0000_0073);
      check("halt_sticky", {31'd0, HALT}, 32'd1);
      ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      RSTn = 1'b0;
      step();
      RSTn = 1'b1;
      check("halt_cleared", {31'd0, HALT}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
